// File: rtl/disp_scan.sv
// Eight-digit 7-segment scan controller: walks the enabled digits once per frame,
// presents each digit's nibble/dp from a per-frame snapshot, and blanks around slot changes.
module disp_scan #(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  digit_mask_i,
  input  logic [31:0] digits_i,
  input  logic [7:0]  dp_i,
  output logic [2:0]  scan_idx_o,
  output logic [3:0]  nibble_o,
  output logic        dp_o,
  output logic        blank_o,
  output logic        frame_start_o
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  typedef struct packed {
    logic [7:0]  mask;
    logic [31:0] digits;
    logic [7:0]  dp;
  } snap_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } hit_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  snap_t         snap_q, snap_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_q, dp_d;
  logic          blank_q, blank_d;
  logic          fs_q, fs_d;

  logic          tick_c;
  hit_t          hit_c;
  logic [2:0]    first_idx_c;

  // Next enabled digit strictly above idx; found=0 means the frame has wrapped.
  function automatic hit_t next_above(input logic [7:0] mask, input logic [2:0] idx);
    hit_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i > int'(idx) && mask[i]) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] sel_nibble(input logic [31:0] d, input logic [2:0] i);
    return d[{i, 2'b00} +: 4];
  endfunction

  assign tick_c      = en_i && (presc_q == PW'(PRESCALE - 1));
  assign hit_c       = next_above(snap_q.mask, idx_q);
  assign first_idx_c = lowest_set(digit_mask_i);

  // Next-state: prescaler, slot advance / frame snapshot, blank timing.
  always_comb begin
    presc_d     = presc_q;
    blank_cnt_d = blank_cnt_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    nib_d       = nib_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    fs_d        = 1'b0;

    if (en_i) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);

      if (blank_cnt_q != '0) blank_cnt_d = blank_cnt_q - BW'(1);

      if (tick_c) begin
        blank_cnt_d = BW'(BLANK_CYCLES);
        if (hit_c.found) begin
          idx_d = hit_c.idx;
          nib_d = sel_nibble(snap_q.digits, hit_c.idx);
          dp_d  = snap_q.dp[hit_c.idx];
        end else begin
          // Frame boundary: new snapshot and first slot both come from the live inputs.
          snap_d.mask   = digit_mask_i;
          snap_d.digits = digits_i;
          snap_d.dp     = dp_i;
          idx_d         = first_idx_c;
          nib_d         = sel_nibble(digits_i, first_idx_c);
          dp_d          = dp_i[first_idx_c];
          fs_d          = 1'b1;
        end
      end

      blank_d = (blank_cnt_d != '0) || (snap_d.mask == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      blank_cnt_q <= BW'(BLANK_CYCLES);
      snap_q      <= '0;
      idx_q       <= '0;
      nib_q       <= '0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      blank_cnt_q <= blank_cnt_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      nib_q       <= nib_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      fs_q        <= fs_d;
    end
  end

  assign scan_idx_o    = idx_q;
  assign nibble_o      = nib_q;
  assign dp_o          = dp_q;
  assign blank_o       = blank_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan (PRESCALE=4, BLANK_CYCLES=1): driver queues hand-derived
// per-cycle outputs, monitor pops and compares them on the falling edge.
module tb_disp_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  mask;
  logic [31:0] digits;
  logic [7:0]  dpin;
  logic [2:0]  scan_idx;
  logic [3:0]  nibble;
  logic        dp;
  logic        blank;
  logic        frame_start;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] nib;
    logic       dp;
    logic       bl;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  disp_scan #(.PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .digit_mask_i  (mask),
    .digits_i      (digits),
    .dp_i          (dpin),
    .scan_idx_o    (scan_idx),
    .nibble_o      (nibble),
    .dp_o          (dp),
    .blank_o       (blank),
    .frame_start_o (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the next rising edge.
  task automatic cyc(input logic [2:0] i, input logic [3:0] n, input logic d,
                     input logic b, input logic f);
    exp_t e;
    e.idx = i; e.nib = n; e.dp = d; e.bl = b; e.fs = f;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // One 4-cycle slot starting at its tick edge: blank high for the first cycle.
  task automatic slot(input logic [2:0] i, input logic [3:0] n, input logic d,
                      input logic f, input logic bl_rest);
    cyc(i, n, d, 1'b1, f);
    repeat (3) cyc(i, n, d, bl_rest, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      cyc_no++;
      if ({scan_idx, nibble, dp, blank, frame_start} !== e) begin
        errors++;
        $display("FAIL cyc%0d: got idx=%0d nib=%h dp=%b blank=%b fs=%b, want idx=%0d nib=%h dp=%b blank=%b fs=%b",
                 cyc_no, scan_idx, nibble, dp, blank, frame_start,
                 e.idx, e.nib, e.dp, e.bl, e.fs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset, then mask F0 scan
    rst = 1'b1; en = 1'b1; mask = 8'hF0; digits = 32'h8765_4321; dpin = 8'hA5;
    cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(3'd4, 4'h5, 1'b0, 1'b1, 1'b0);
    slot(3'd5, 4'h6, 1'b1, 1'b0, 1'b0);
    slot(3'd6, 4'h7, 1'b0, 1'b0, 1'b0);
    slot(3'd7, 4'h8, 1'b1, 1'b0, 1'b0);
    slot(3'd4, 4'h5, 1'b0, 1'b1, 1'b0);
    slot(3'd5, 4'h6, 1'b1, 1'b0, 1'b0);

    // Mid-frame input change only lands at the next boundary
    mask = 8'h0F; digits = 32'h0; dpin = 8'h00;
    slot(3'd6, 4'h7, 1'b0, 1'b0, 1'b0);
    slot(3'd7, 4'h8, 1'b1, 1'b0, 1'b0);
    slot(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
    slot(3'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    slot(3'd3, 4'h0, 1'b0, 1'b0, 1'b0);

    // Empty mask: permanently blank, boundary every tick
    mask = 8'h00;
    repeat (3) slot(3'd0, 4'h0, 1'b0, 1'b1, 1'b1);

    // Mask 81: alternate 0/7, frame_start only on 7->0
    mask = 8'h81; digits = 32'h9000_0003; dpin = 8'h80;
    slot(3'd0, 4'h3, 1'b0, 1'b1, 1'b0);
    slot(3'd7, 4'h9, 1'b1, 1'b0, 1'b0);
    slot(3'd0, 4'h3, 1'b0, 1'b1, 1'b0);
    slot(3'd7, 4'h9, 1'b1, 1'b0, 1'b0);

    // en low right after a tick: blank holds, frame_start drops, slot resumes
    cyc(3'd0, 4'h3, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    repeat (10) cyc(3'd0, 4'h3, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    repeat (3) cyc(3'd0, 4'h3, 1'b0, 1'b0, 1'b0);
    slot(3'd7, 4'h9, 1'b1, 1'b0, 1'b0);

    // Reset mid-slot, then single-digit mask 10
    cyc(3'd0, 4'h3, 1'b0, 1'b1, 1'b1);
    cyc(3'd0, 4'h3, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; mask = 8'h10; digits = 32'h000B_0000; dpin = 8'h10;
    cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) slot(3'd4, 4'hB, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
